// File: rtl/riscv_tb_pkg.sv
// Shared types and default register indices for the RISC-V test completion monitor.
package riscv_tb_pkg;

    typedef enum logic [1:0] {
        RUN,
        SETTLE,
        VERDICT,
        DONE
    } mon_state_e;

    localparam int unsigned REG_DONE = 26;
    localparam int unsigned REG_PASS = 27;
    localparam int unsigned REG_NUM  = 3;

endpackage

// File: rtl/riscv_test_monitor_shadow.sv
// Snoops one register-file index and keeps a shadow copy of its last written value.
// Index 0 is never captured; freeze holds the value once the verdict is final.
module riscv_test_monitor_shadow #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] index,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              freeze,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              hit;

    assign hit = we && (waddr == index) && (index != '0) && !freeze;

    always_comb begin
        value_d = value_q;
        if (hit) begin
            value_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Completion monitor: snoops register writes, waits for the done marker, settles, then
// latches sticky verdicts. Define RISCV_TEST_MONITOR_TRACE_EN for per-cycle $display tracing.
module riscv_test_monitor
    import riscv_tb_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DONE_REG    = REG_DONE,
    parameter int unsigned PASS_REG    = REG_PASS,
    parameter int unsigned NUM_REG     = REG_NUM,
    parameter int unsigned SETTLE_CYC  = 10,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] fail_testnum,
    output logic [CNT_W-1:0]  cycles
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    mon_state_e        state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              to_path_q, to_path_d;
    logic [DATA_W-1:0] testnum_q, testnum_d;

    logic [DATA_W-1:0] done_sh, pass_sh, num_sh;
    logic              freeze;
    logic              done_hit;
    logic              to_hit;

    assign freeze = (state_q == DONE);

    riscv_test_monitor_shadow #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_done_sh (
        .clk(clk), .rst(rst), .index(ADDR_W'(DONE_REG)), .we(rf_we), .waddr(rf_waddr),
        .wdata(rf_wdata), .freeze(freeze), .value(done_sh)
    );

    riscv_test_monitor_shadow #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pass_sh (
        .clk(clk), .rst(rst), .index(ADDR_W'(PASS_REG)), .we(rf_we), .waddr(rf_waddr),
        .wdata(rf_wdata), .freeze(freeze), .value(pass_sh)
    );

    riscv_test_monitor_shadow #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_num_sh (
        .clk(clk), .rst(rst), .index(ADDR_W'(NUM_REG)), .we(rf_we), .waddr(rf_waddr),
        .wdata(rf_wdata), .freeze(freeze), .value(num_sh)
    );

    // The done marker is taken from the raw write so SETTLE is entered on the write edge itself.
    assign done_hit = rf_we && (rf_waddr == ADDR_W'(DONE_REG)) && (DONE_REG != 0)
                      && (rf_wdata == DATA_W'(1));
    assign to_hit   = (cycles_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        to_path_d = to_path_q;
        testnum_d = testnum_q;
        unique case (state_q)
            RUN: begin
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (done_hit) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end else if (to_hit) begin
                    state_d   = VERDICT;
                    to_path_d = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = VERDICT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            VERDICT: begin
                done_d    = 1'b1;
                pass_d    = (pass_sh == DATA_W'(1));
                fail_d    = (pass_sh != DATA_W'(1));
                timeout_d = to_path_q;
                testnum_d = num_sh;
                state_d   = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            settle_q  <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            to_path_q <= 1'b0;
            testnum_q <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cycles_q  <= cycles_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            to_path_q <= to_path_d;
            testnum_q <= testnum_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign fail_testnum = testnum_q;
    assign cycles       = cycles_q;

`ifdef RISCV_TEST_MONITOR_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == RUN || state_q == SETTLE) begin
                $display("[mon] done_sh=%0h pass_sh=%0h num_sh=%0h cycles=%0d",
                         done_sh, pass_sh, num_sh, cycles_q);
            end else if (state_q == VERDICT) begin
                if (pass_sh == DATA_W'(1)) begin
                    $display("[mon] *** TEST PASS *** testnum=%0d", num_sh);
                end else begin
                    $display("[mon] *** TEST FAIL *** testnum=%0d", num_sh);
                end
            end
        end
    end
`else
    // The done shadow only feeds the trace; keep it referenced in the quiet build.
    logic done_sh_unused;
    assign done_sh_unused = ^done_sh;
`endif

endmodule
